// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with optional 2-entry skid buffer,
// built-in exception flush, bubble insertion, a sticky sideband and
// saturating stall/bubble performance counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned STICKY_W = 1,
    parameter int unsigned SKID_EN  = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [STICKY_W-1:0] in_sticky,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [STICKY_W-1:0] out_sticky,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_FULL_SKID = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [STICKY_W-1:0] main_sticky_q, main_sticky_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [STICKY_W-1:0] skid_sticky_q, skid_sticky_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
    logic                in_fire, out_fire;

    // Ready: registered skid-state decode with skid, otherwise pass-through;
    // flush always blocks acceptance in the same cycle.
    assign in_ready  = ((SKID_EN != 0) ? in_ready_q : (out_ready | ~out_valid)) & ~flush;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_sticky = main_sticky_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and datapath update for main register and skid entry.
    always_comb begin
        state_d       = state_q;
        main_data_d   = main_data_q;
        main_sticky_d = main_sticky_q;
        skid_data_d   = skid_data_q;
        skid_sticky_d = skid_sticky_q;

        if (flush) begin
            state_d       = ST_EMPTY;
            main_data_d   = '0;
            main_sticky_d = '0;
            skid_data_d   = '0;
            skid_sticky_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_d   = in_data;
                        main_sticky_d = in_sticky;
                        state_d       = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_fire && in_fire) begin
                        main_data_d   = in_data;
                        main_sticky_d = in_sticky;
                    end else if (out_fire) begin
                        // Bubble: payload cleared, sideband held.
                        main_data_d = '0;
                        state_d     = ST_EMPTY;
                    end else if (in_fire && (SKID_EN != 0)) begin
                        skid_data_d   = in_data;
                        skid_sticky_d = in_sticky;
                        state_d       = ST_FULL_SKID;
                    end
                end
                ST_FULL_SKID: begin
                    if (out_fire) begin
                        main_data_d   = skid_data_q;
                        main_sticky_d = skid_sticky_q;
                        skid_data_d   = '0;
                        skid_sticky_d = '0;
                        state_d       = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != ST_FULL_SKID);
    end

    // Saturating performance counters based on pre-edge handshake signals.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            main_data_q   <= '0;
            main_sticky_q <= '0;
            skid_data_q   <= '0;
            skid_sticky_q <= '0;
            in_ready_q    <= 1'b1;
            stall_cnt_q   <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            main_data_q   <= main_data_d;
            main_sticky_q <= main_sticky_d;
            skid_data_q   <= skid_data_d;
            skid_sticky_q <= skid_sticky_d;
            in_ready_q    <= in_ready_d;
            stall_cnt_q   <= stall_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid instance (CNT_W=4) and
// pass-through instance (SKID_EN=0).
module tb_pipe_stage_skid;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;

    logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [0:0]    s_in_sticky, s_out_sticky;
    logic [3:0]    s_stall, s_bubble;

    logic          p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [DW-1:0] p_in_data, p_out_data;
    logic [0:0]    p_in_sticky, p_out_sticky;
    logic [7:0]    p_stall, p_bubble;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .STICKY_W(1), .SKID_EN(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_sticky(s_in_sticky),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_sticky(s_out_sticky),
        .stall_cnt(s_stall), .bubble_cnt(s_bubble)
    );

    pipe_stage_skid #(.DATA_W(DW), .STICKY_W(1), .SKID_EN(0), .CNT_W(8)) u_pass (
        .clk(clk), .rst(rst), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_data(p_in_data), .in_sticky(p_in_sticky),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_data(p_out_data), .out_sticky(p_out_sticky),
        .stall_cnt(p_stall), .bubble_cnt(p_bubble)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1-2 time units after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0; s_in_sticky = '0;
        p_flush = 0; p_in_valid = 0; p_out_ready = 0; p_in_data = '0; p_in_sticky = '0;
        step();
        step();
        rst = 1'b0;
        settle();
        chk("rst_valid",  64'(s_out_valid), 64'd0);
        chk("rst_data",   64'(s_out_data),  64'd0);
        chk("rst_sticky", 64'(s_out_sticky), 64'd0);
        chk("rst_ready",  64'(s_in_ready),  64'd1);
        chk("rst_stall",  64'(s_stall),     64'd0);
        chk("rst_bubble", 64'(s_bubble),    64'd0);

        // Streaming 1..4 with out_ready=1; first cycle is one bubble.
        s_out_ready = 1;
        s_in_valid  = 1;
        for (int i = 1; i <= 4; i++) begin
            s_in_data = DW'(i);
            settle();
            chk("stream_ready", 64'(s_in_ready), 64'd1);
            step();
            chk("stream_data",  64'(s_out_data),  64'(i));
            chk("stream_valid", 64'(s_out_valid), 64'd1);
        end
        s_in_valid = 0;
        settle();
        chk("stream_stall", 64'(s_stall), 64'd0);
        step();
        chk("drain_valid", 64'(s_out_valid), 64'd0);
        chk("drain_data",  64'(s_out_data),  64'd0);

        // Backpressure: 0xA held in main, 0xB lands in skid.
        s_out_ready = 0;
        s_in_valid  = 1;
        s_in_data   = DW'(32'hA);
        step();
        s_in_data = DW'(32'hB);
        settle();
        chk("bp_ready_full", 64'(s_in_ready), 64'd1);
        step();
        s_in_valid = 0;
        settle();
        chk("bp_ready_skid", 64'(s_in_ready),  64'd0);
        chk("bp_hold_a",     64'(s_out_data),  64'hA);
        step();
        chk("bp_hold_a2",    64'(s_out_data),  64'hA);
        chk("bp_ready_skid2", 64'(s_in_ready), 64'd0);
        chk("bp_stall",      64'(s_stall),     64'd2);
        s_out_ready = 1;
        step();
        chk("bp_emit_b",     64'(s_out_data),  64'hB);
        chk("bp_valid_b",    64'(s_out_valid), 64'd1);
        chk("bp_ready_back", 64'(s_in_ready),  64'd1);
        step();
        chk("bp_empty",      64'(s_out_valid), 64'd0);
        chk("bp_stall_end",  64'(s_stall),     64'd2);

        // Bubble keeps sticky, clears payload.
        s_in_valid  = 1;
        s_in_data   = DW'(32'h55);
        s_in_sticky = 1'b1;
        step();
        s_in_valid  = 0;
        s_in_sticky = 1'b0;
        settle();
        chk("bub_data",    64'(s_out_data),   64'h55);
        chk("bub_sticky",  64'(s_out_sticky), 64'd1);
        step();
        chk("bub_valid",   64'(s_out_valid),  64'd0);
        chk("bub_zero",    64'(s_out_data),   64'd0);
        chk("bub_held",    64'(s_out_sticky), 64'd1);
        chk("bub_cnt_a",   64'(s_bubble),     64'd2);
        step();
        step();
        chk("bub_cnt_b",   64'(s_bubble),     64'd4);
        chk("bub_held2",   64'(s_out_sticky), 64'd1);

        // Flush while FULL_SKID with a same-cycle incoming entry.
        s_out_ready = 0;
        s_in_valid  = 1;
        s_in_sticky = 1'b1;
        s_in_data   = DW'(32'h11);
        step();
        s_in_data = DW'(32'h22);
        step();
        s_in_data = DW'(32'h33);
        s_flush   = 1;
        settle();
        chk("fl_ready_comb", 64'(s_in_ready), 64'd0);
        step();
        s_flush    = 0;
        s_in_valid = 0;
        settle();
        chk("fl_valid",  64'(s_out_valid),  64'd0);
        chk("fl_data",   64'(s_out_data),   64'd0);
        chk("fl_sticky", 64'(s_out_sticky), 64'd0);
        chk("fl_ready",  64'(s_in_ready),   64'd1);
        chk("fl_stall",  64'(s_stall),      64'd4);
        s_out_ready = 1;
        step();
        chk("fl_dropped", 64'(s_out_valid), 64'd0);
        chk("fl_bubble",  64'(s_bubble),    64'd5);

        // Reset mid-operation with stall_cnt=7.
        s_out_ready = 0;
        s_in_valid  = 1;
        s_in_data   = DW'(32'h77);
        step();
        s_in_valid = 0;
        step();
        step();
        step();
        chk("mid_stall", 64'(s_stall),    64'd7);
        chk("mid_data",  64'(s_out_data), 64'h77);
        rst = 1;
        step();
        rst = 0;
        settle();
        chk("mid_rst_valid",  64'(s_out_valid),  64'd0);
        chk("mid_rst_data",   64'(s_out_data),   64'd0);
        chk("mid_rst_sticky", 64'(s_out_sticky), 64'd0);
        chk("mid_rst_stall",  64'(s_stall),      64'd0);
        chk("mid_rst_bubble", 64'(s_bubble),     64'd0);
        chk("mid_rst_ready",  64'(s_in_ready),   64'd1);

        // Saturation at 15 after 20 stalled cycles.
        s_in_valid = 1;
        s_in_data  = DW'(32'h99);
        step();
        s_in_valid = 0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", 64'(s_stall),    64'd15);
        chk("sat_data",  64'(s_out_data), 64'h99);

        // Pass-through mode: combinational in_ready, one entry per cycle.
        p_out_ready = 0;
        p_in_valid  = 1;
        p_in_data   = DW'(32'h100);
        settle();
        chk("p_ready_empty", 64'(p_in_ready), 64'd1);
        step();
        p_in_data = DW'(32'h101);
        settle();
        chk("p_ready_blocked", 64'(p_in_ready), 64'd0);
        chk("p_data0",         64'(p_out_data), 64'h100);
        p_out_ready = 1;
        settle();
        chk("p_ready_open",    64'(p_in_ready), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("p_stream", 64'(p_out_data), 64'(32'h100 + i));
            p_in_data = DW'(32'h101 + i);
        end
        p_in_valid = 0;
        step();
        chk("p_empty", 64'(p_out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
